// File: rtl/id_inst_queue.sv
// Decode-stage instruction queue: circular buffer between IF/SRAM and decode.
// Optional same-cycle empty-queue bypass enabled by defining ID_IQ_BYPASS_EN.
module id_inst_queue #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [INST_W-1:0]          in_inst,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [PC_W-1:0]            out_pc,
   output logic [INST_W-1:0]          out_inst,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   entry_t         mem [DEPTH];
   entry_t         head;
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  cnt;
   logic           has_data, push, wr_en, rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign has_data = (cnt != '0);
   assign in_ready = (cnt < CW'(DEPTH));
   assign push     = in_valid & in_ready;
   assign rd_en    = out_ready & has_data;
   assign count    = cnt;

`ifdef ID_IQ_BYPASS_EN
   // Empty queue: the incoming word is presented directly; if decode takes it
   // the same cycle it never lands in storage.
   assign out_valid = has_data | in_valid;
   assign head      = has_data ? mem[rd_ptr] : entry_t'{pc: in_pc, inst: in_inst};
   assign wr_en     = push & ~(~has_data & out_ready);
`else
   assign out_valid = has_data;
   assign head      = mem[rd_ptr];
   assign wr_en     = push;
`endif

   // Bubble when empty so decode never sees stale storage contents.
   assign out_pc   = out_valid ? head.pc   : '0;
   assign out_inst = out_valid ? head.inst : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Instruction captured in the push cycle; SRAM data is never re-read.
   always_ff @(posedge clk) begin
      if (wr_en && !flush && !rst)
         mem[wr_ptr] <= entry_t'{pc: in_pc, inst: in_inst};
   end
endmodule

// File: tb/tb_id_inst_queue.sv
// Bench for id_inst_queue: DEPTH=4 instance for most scenarios, DEPTH=3 for wrap stress.
module tb_id_inst_queue;
   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_pc = '0, in_inst = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_inst;
   logic [2:0]  count;

   logic        in_valid3 = 1'b0, out_ready3 = 1'b0;
   logic [31:0] in_pc3 = '0, in_inst3 = '0;
   logic        in_ready3, out_valid3;
   logic [31:0] out_pc3, out_inst3;
   logic [1:0]  count3;

   logic [63:0] sb[$];
   logic [63:0] sb3[$];
   int checks = 0, passed = 0;

   id_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
      .in_inst(in_inst), .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
      .out_inst(out_inst), .out_ready(out_ready), .count(count));

   id_inst_queue #(.DEPTH(3), .PC_W(32), .INST_W(32)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid3), .in_pc(in_pc3),
      .in_inst(in_inst3), .in_ready(in_ready3), .out_valid(out_valid3), .out_pc(out_pc3),
      .out_inst(out_inst3), .out_ready(out_ready3), .count(count3));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic drive(input logic v, input logic [31:0] pc, input logic r, input logic f);
      @(negedge clk);
      in_valid = v; in_pc = pc; in_inst = pc ^ 32'h5A5A0000; out_ready = r; flush = f;
      #1;
   endtask

   // Advance one edge and update both reference queues from the inputs seen at that edge.
   task automatic tick();
      bit p, q, p3, q3;
      p  = in_valid  && sb.size()  < 4;  q  = out_ready  && sb.size()  > 0;
      p3 = in_valid3 && sb3.size() < 3;  q3 = out_ready3 && sb3.size() > 0;
`ifdef ID_IQ_BYPASS_EN
      if (sb.size() == 0 && in_valid && out_ready) p = 1'b0;
      if (sb3.size() == 0 && in_valid3 && out_ready3) p3 = 1'b0;
`endif
      @(posedge clk);
      if (rst || flush) begin
         sb.delete(); sb3.delete();
      end else begin
         if (q)  void'(sb.pop_front());
         if (p)  sb.push_back({in_pc, in_inst});
         if (q3) void'(sb3.pop_front());
         if (p3) sb3.push_back({in_pc3, in_inst3});
      end
   endtask

   task automatic test_reset();
      #1;
      checks++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
      checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0)
         $display("FAIL reset_out_data: got %h/%h want 0/0", out_pc, out_inst); else passed++;
      checks++; if (count3 !== 2'd0) $display("FAIL reset_count3: got %0d want 0", count3); else passed++;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h100 + 32'(4*i), 1'b0, 1'b0);
         checks++; if (in_ready !== (sb.size() < 4))
            $display("FAIL fill_in_ready[%0d]: got %b want %b", i, in_ready, sb.size() < 4); else passed++;
         checks++; if (count !== 3'(sb.size()))
            $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, sb.size()); else passed++;
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (count !== 3'd4 || in_ready !== 1'b0)
         $display("FAIL full_state: got count %0d rdy %b want 4/0", count, in_ready); else passed++;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         checks++; if (out_valid !== 1'b1 || out_pc !== sb[0][63:32] || out_inst !== sb[0][31:0])
            $display("FAIL drain_head[%0d]: got %b %h/%h want 1 %h/%h", i, out_valid, out_pc,
                     out_inst, sb[0][63:32], sb[0][31:0]); else passed++;
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (count !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL drain_empty: got count %0d vld %b want 0/0", count, out_valid); else passed++;
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'h1F8, 1'b0, 1'b0); tick();
      drive(1'b1, 32'h1FC, 1'b0, 1'b0); tick();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 32'h200 + 32'(4*i), 1'b1, 1'b0);
         checks++; if (count !== 3'd2)
            $display("FAIL b2b_count[%0d]: got %0d want 2", i, count); else passed++;
         checks++; if (out_pc !== sb[0][63:32] || out_inst !== sb[0][31:0])
            $display("FAIL b2b_head[%0d]: got %h/%h want %h/%h", i, out_pc, out_inst,
                     sb[0][63:32], sb[0][31:0]); else passed++;
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0);
         checks++; if (out_pc !== sb[0][63:32])
            $display("FAIL b2b_drain[%0d]: got %h want %h", i, out_pc, sb[0][63:32]); else passed++;
         tick();
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin drive(1'b1, 32'h500 + 32'(4*i), 1'b0, 1'b0); tick(); end
      drive(1'b1, 32'h600, 1'b1, 1'b1); tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (count !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL flush_state: got count %0d vld %b want 0/0", count, out_valid); else passed++;
      checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0)
         $display("FAIL flush_bubble: got %h/%h want 0/0", out_pc, out_inst); else passed++;
      drive(1'b1, 32'h700, 1'b0, 1'b0); tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (out_pc !== 32'h700 || out_inst !== (32'h700 ^ 32'h5A5A0000))
         $display("FAIL flush_refill: got %h/%h want 700/%h", out_pc, out_inst,
                  32'h700 ^ 32'h5A5A0000); else passed++;
      tick();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin drive(1'b1, 32'h900 + 32'(4*i), 1'b0, 1'b0); tick(); end
      @(negedge clk); in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL arst_state: got count %0d vld %b want 0/0", count, out_valid); else passed++;
      checks++; if (out_pc !== 32'h0 || in_ready !== 1'b1)
         $display("FAIL arst_outs: got pc %h rdy %b want 0/1", out_pc, in_ready); else passed++;
      sb.delete(); sb3.delete();
      #1 rst = 1'b0;
      drive(1'b1, 32'h300, 1'b0, 1'b0); tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300)
         $display("FAIL arst_first_push: got %b %h want 1 300", out_valid, out_pc); else passed++;
      tick();
   endtask

   task automatic test_bypass();
      drive(1'b1, 32'h400, 1'b1, 1'b0);
      in_inst = 32'h3C010001; #1;
`ifdef ID_IQ_BYPASS_EN
      checks++; if (out_valid !== 1'b1 || out_inst !== 32'h3C010001 || out_pc !== 32'h400)
         $display("FAIL bypass_same_cycle: got %b %h/%h want 1 400/3c010001", out_valid, out_pc,
                  out_inst); else passed++;
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (count !== 3'd0 || out_valid !== 1'b0)
         $display("FAIL bypass_count: got %0d %b want 0/0", count, out_valid); else passed++;
`else
      checks++; if (out_valid !== 1'b0 || out_inst !== 32'h0)
         $display("FAIL nobypass_same_cycle: got %b %h want 0 0", out_valid, out_inst); else passed++;
      tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (count !== 3'd1 || out_valid !== 1'b1 || out_inst !== 32'h3C010001)
         $display("FAIL nobypass_next: got %0d %b %h want 1 1 3c010001", count, out_valid,
                  out_inst); else passed++;
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (count !== 3'd0)
         $display("FAIL nobypass_drain: got %0d want 0", count); else passed++;
`endif
   endtask

   task automatic test_depth3();
      int n;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         in_valid3 = (i % 4 != 3); out_ready3 = (i >= 4) && (i % 3 != 0);
         in_pc3 = 32'h800 + 32'(4*i); in_inst3 = ~in_pc3;
         #1;
         checks++; if (count3 !== 2'(sb3.size()) || in_ready3 !== (sb3.size() < 3))
            $display("FAIL d3_count[%0d]: got %0d rdy %b want %0d", i, count3, in_ready3,
                     sb3.size()); else passed++;
         if (sb3.size() > 0) begin
            checks++; if (out_pc3 !== sb3[0][63:32] || out_inst3 !== sb3[0][31:0])
               $display("FAIL d3_head[%0d]: got %h/%h want %h/%h", i, out_pc3, out_inst3,
                        sb3[0][63:32], sb3[0][31:0]); else passed++;
         end
         tick();
      end
      n = 0;
      while (sb3.size() > 0 && n < 4) begin
         @(negedge clk); in_valid3 = 1'b0; out_ready3 = 1'b1; #1;
         checks++; if (out_valid3 !== 1'b1 || out_pc3 !== sb3[0][63:32])
            $display("FAIL d3_drain[%0d]: got %b %h want 1 %h", n, out_valid3, out_pc3,
                     sb3[0][63:32]); else passed++;
         tick(); n++;
      end
      @(negedge clk); out_ready3 = 1'b0; #1;
      checks++; if (count3 !== 2'd0 || out_valid3 !== 1'b0)
         $display("FAIL d3_empty: got %0d %b want 0/0", count3, out_valid3); else passed++;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_bypass();
      test_depth3();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
